// File: rtl/hdmi_line_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_line_fetch_ctrl_pkg
// Description : Shared types and constants for the HDMI line fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_line_fetch_ctrl_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_BEGIN   = 2'd2,
        S_DATA    = 2'd3
    } fetch_state_t;

    // Default maximum words per bus burst
    localparam int c_BURST_WORDS_DEFAULT = 16;

    // A lineWords value of zero stands for a full 256-word line
    localparam logic [8:0] c_LINE_WORDS_ZERO = 9'd256;

    // Expand the 8-bit line length into a 9-bit word count
    function automatic logic [8:0] decode_line_words(input logic [7:0] words);
        return (words == 8'd0) ? c_LINE_WORDS_ZERO : {1'b0, words};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_burst_len.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_burst_len
// Description : Length of the next burst: min(remaining words, BURST_WORDS).
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_burst_len #(
    parameter int BURST_WORDS = 16
) (
    input  logic [8:0] remaining,
    output logic [8:0] burst_len
);

    localparam logic [8:0] c_MAX_WORDS = 9'(BURST_WORDS);

    // Clamp the outstanding word count to the largest allowed burst
    always_comb begin
        burst_len = (remaining > c_MAX_WORDS) ? c_MAX_WORDS : remaining;
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_line_fetch_ctrl
// Description : Fetches video lines over a burst read bus into a two-bank
//               line buffer, ping-ponging banks line by line.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_line_fetch_ctrl
    import hdmi_line_fetch_ctrl_pkg::*;
#(
    parameter int BURST_WORDS    = c_BURST_WORDS_DEFAULT,
    parameter int LINE_BANK_BITS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               frameBaseAddress,
    input  logic [7:0]                lineWords,
    input  logic                      startFrame,
    input  logic                      lineRequest,
    output logic                      lineDone,
    output logic                      readBank,
    output logic                      busy,
    output logic                      overrun,
    output logic                      busErrorFlag,
    output logic                      busRequest,
    input  logic                      busGrant,
    output logic                      beginTransaction,
    output logic [31:0]               addressData,
    output logic [7:0]                burstSize,
    input  logic                      dataValid,
    input  logic [31:0]               dataIn,
    input  logic                      endTransaction,
    input  logic                      busError,
    output logic [LINE_BANK_BITS:0]   ramAddress,
    output logic                      ramWriteEnable,
    output logic [31:0]               ramDataIn
);

    localparam logic [LINE_BANK_BITS-1:0] c_IDX_ONE = 1;

    fetch_state_t               r_state;
    fetch_state_t               w_next_state;
    logic [8:0]                 r_remaining;
    logic [8:0]                 r_line_words;
    logic [8:0]                 r_burst_left;
    logic [LINE_BANK_BITS-1:0]  r_word_index;
    logic [31:0]                r_line_addr;
    logic                       r_fill_bank;
    logic                       r_read_bank;
    logic                       r_pending_start;
    logic                       r_overrun;
    logic                       r_bus_err;
    logic                       r_line_done;

    logic [8:0]                 w_burst_len;
    logic [8:0]                 w_offset;
    logic [8:0]                 w_rem_after;
    logic [31:0]                w_fetch_addr;
    logic [31:0]                w_line_bytes;
    logic                       w_beat;
    logic                       w_line_end;
    logic                       w_abort;

    hdmi_burst_len #(
        .BURST_WORDS (BURST_WORDS)
    ) u_burst_len (
        .remaining (r_remaining),
        .burst_len (w_burst_len)
    );

    // Words already fetched give the byte offset of the next burst
    assign w_offset     = r_line_words - r_remaining;
    assign w_fetch_addr = r_line_addr + {21'd0, w_offset, 2'b00};
    assign w_line_bytes = {21'd0, r_line_words, 2'b00};
    assign w_rem_after  = r_remaining - {8'd0, w_beat};

    assign busy         = (r_state != S_IDLE);
    assign lineDone     = r_line_done;
    assign readBank     = r_read_bank;
    assign overrun      = r_overrun;
    assign busErrorFlag = r_bus_err;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and bus / line-buffer port drive
    always_comb begin
        w_next_state     = r_state;
        busRequest       = 1'b0;
        beginTransaction = 1'b0;
        addressData      = 32'd0;
        burstSize        = 8'd0;
        ramWriteEnable   = 1'b0;
        ramAddress       = '0;
        ramDataIn        = 32'd0;
        w_beat           = 1'b0;
        w_line_end       = 1'b0;
        w_abort          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lineRequest) begin
                    w_next_state = S_REQUEST;
                end
            end
            S_REQUEST: begin
                busRequest = 1'b1;
                if (busGrant) begin
                    w_next_state = S_BEGIN;
                end
            end
            S_BEGIN: begin
                beginTransaction = 1'b1;
                addressData      = w_fetch_addr;
                burstSize        = 8'(w_burst_len - 9'd1);
                if (busError) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    busRequest   = 1'b1;
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                busRequest = !(endTransaction || busError);
                if (busError) begin
                    // Data accompanying an error is not trusted; drop the line
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    // Beats past the granted burst length are discarded
                    w_beat = dataValid && (r_burst_left != 9'd0);
                    if (w_beat) begin
                        ramWriteEnable = 1'b1;
                        ramAddress     = {r_fill_bank, r_word_index};
                        ramDataIn      = dataIn;
                    end
                    if (endTransaction) begin
                        if (w_rem_after == 9'd0) begin
                            w_line_end   = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = S_REQUEST;
                        end
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Line bookkeeping: counters, bank ping-pong, address advance and flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_remaining     <= 9'd0;
            r_line_words    <= 9'd0;
            r_burst_left    <= 9'd0;
            r_word_index    <= '0;
            r_line_addr     <= 32'd0;
            r_fill_bank     <= 1'b0;
            r_read_bank     <= 1'b1;
            r_pending_start <= 1'b0;
            r_overrun       <= 1'b0;
            r_bus_err       <= 1'b0;
            r_line_done     <= 1'b0;
        end else begin
            r_line_done <= 1'b0;

            if (r_state != S_IDLE) begin
                if (lineRequest) begin
                    r_overrun <= 1'b1;
                end
                if (startFrame) begin
                    r_pending_start <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    // Rewind first so a simultaneous request fetches from the base
                    if (startFrame) begin
                        r_line_addr <= frameBaseAddress;
                        r_fill_bank <= 1'b0;
                        r_read_bank <= 1'b1;
                        r_overrun   <= 1'b0;
                        r_bus_err   <= 1'b0;
                    end
                    if (lineRequest) begin
                        r_remaining  <= decode_line_words(lineWords);
                        r_line_words <= decode_line_words(lineWords);
                        r_word_index <= '0;
                    end
                end
                S_BEGIN: begin
                    r_burst_left <= w_burst_len;
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_word_index <= r_word_index + c_IDX_ONE;
                        r_remaining  <= w_rem_after;
                        r_burst_left <= r_burst_left - 9'd1;
                    end
                end
                default: begin
                end
            endcase

            if (w_abort) begin
                r_bus_err <= 1'b1;
            end

            if (w_line_end) begin
                r_line_done <= 1'b1;
                r_read_bank <= r_fill_bank;
                r_fill_bank <= ~r_fill_bank;
                r_line_addr <= r_line_addr + w_line_bytes;
            end

            // A frame restart requested mid-line lands once the line is over;
            // the flags recorded during that line are kept
            if (w_abort || w_line_end) begin
                r_pending_start <= 1'b0;
                if (r_pending_start || startFrame) begin
                    r_line_addr <= frameBaseAddress;
                    r_fill_bank <= 1'b0;
                    r_read_bank <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_line_fetch_ctrl
// Description : Directed self-checking bench for hdmi_line_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_line_fetch_ctrl;

    localparam int BURST_WORDS    = 16;
    localparam int LINE_BANK_BITS = 8;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [31:0]             frameBaseAddress = 32'd0;
    logic [7:0]              lineWords = 8'd0;
    logic                    startFrame = 1'b0;
    logic                    lineRequest = 1'b0;
    logic                    lineDone;
    logic                    readBank;
    logic                    busy;
    logic                    overrun;
    logic                    busErrorFlag;
    logic                    busRequest;
    logic                    busGrant = 1'b1;
    logic                    beginTransaction;
    logic [31:0]             addressData;
    logic [7:0]              burstSize;
    logic                    dataValid = 1'b0;
    logic [31:0]             dataIn = 32'd0;
    logic                    endTransaction = 1'b0;
    logic                    busError = 1'b0;
    logic [LINE_BANK_BITS:0] ramAddress;
    logic                    ramWriteEnable;
    logic [31:0]             ramDataIn;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] bt_addr_q[$];
    int          bt_size_q[$];
    int          done_cnt = 0;

    always #5 clock = ~clock;

    hdmi_line_fetch_ctrl #(
        .BURST_WORDS    (BURST_WORDS),
        .LINE_BANK_BITS (LINE_BANK_BITS)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .frameBaseAddress (frameBaseAddress),
        .lineWords        (lineWords),
        .startFrame       (startFrame),
        .lineRequest      (lineRequest),
        .lineDone         (lineDone),
        .readBank         (readBank),
        .busy             (busy),
        .overrun          (overrun),
        .busErrorFlag     (busErrorFlag),
        .busRequest       (busRequest),
        .busGrant         (busGrant),
        .beginTransaction (beginTransaction),
        .addressData      (addressData),
        .burstSize        (burstSize),
        .dataValid        (dataValid),
        .dataIn           (dataIn),
        .endTransaction   (endTransaction),
        .busError         (busError),
        .ramAddress       (ramAddress),
        .ramWriteEnable   (ramWriteEnable),
        .ramDataIn        (ramDataIn)
    );

    // Log RAM writes, burst starts and line completions mid-cycle
    always @(negedge clock) begin
        if (ramWriteEnable) begin
            wr_addr_q.push_back(int'(ramAddress));
            wr_data_q.push_back(ramDataIn);
        end
        if (beginTransaction) begin
            bt_addr_q.push_back(addressData);
            bt_size_q.push_back(int'(burstSize));
        end
        if (lineDone) begin
            done_cnt++;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        bt_addr_q.delete();
        bt_size_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_request();
        lineRequest = 1'b1;
        step();
        lineRequest = 1'b0;
    endtask

    task automatic pulse_start();
        startFrame = 1'b1;
        step();
        startFrame = 1'b0;
    endtask

    // Serve every burst of the current line; err_beat (1-based) injects busError,
    // extra adds a surplus dataValid beat at the end of the first burst
    task automatic bus_line(input int err_beat, input bit extra);
        int beat;
        int guard;
        int nb;
        bit fin;
        bit xtra;
        beat  = 0;
        guard = 0;
        fin   = 1'b0;
        xtra  = extra;
        while (!fin) begin
            while (busy && !beginTransaction && guard < 5000) begin
                step();
                guard++;
            end
            if (guard >= 5000) begin
                check_value("bus_wait_begin", {31'd0, beginTransaction}, 32'd1);
                fin = 1'b1;
            end else if (!busy) begin
                fin = 1'b1;
            end else begin
                nb = int'(burstSize) + 1;
                step();
                for (int i = 0; i < nb; i++) begin
                    beat++;
                    dataValid      = 1'b1;
                    dataIn         = 32'hA500_0000 + 32'(beat - 1);
                    busError       = (beat == err_beat);
                    endTransaction = (i == nb - 1) && !xtra && !busError;
                    step();
                    if (busError) begin
                        fin = 1'b1;
                        break;
                    end
                end
                if (!fin && xtra) begin
                    dataValid      = 1'b1;
                    dataIn         = 32'hDEAD_BEEF;
                    endTransaction = 1'b1;
                    step();
                    xtra = 1'b0;
                end
                dataValid      = 1'b0;
                busError       = 1'b0;
                endTransaction = 1'b0;
            end
        end
        repeat (2) step();
    endtask

    task automatic check_writes(input string tag, input int n, input int first);
        int bad;
        bad = 0;
        check_value({tag, "_wr_count"}, wr_addr_q.size(), n);
        foreach (wr_addr_q[i]) begin
            if (wr_addr_q[i] != first + i || wr_data_q[i] != 32'hA500_0000 + 32'(i)) begin
                bad++;
            end
        end
        check_value({tag, "_wr_seq"}, bad, 0);
    endtask

    task automatic check_bursts(input string tag, input int n, input logic [31:0] first,
                                input int last_size);
        int bad;
        bad = 0;
        check_value({tag, "_bt_count"}, bt_addr_q.size(), n);
        check_value({tag, "_bt_first"}, (bt_addr_q.size() > 0) ? bt_addr_q[0] : 32'hFFFF_FFFF, first);
        foreach (bt_addr_q[i]) begin
            if (bt_addr_q[i] != first + 32'(64 * i)) bad++;
            if (bt_size_q[i] != ((i == n - 1) ? last_size : 15)) bad++;
        end
        check_value({tag, "_bt_seq"}, bad, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_readBank", {31'd0, readBank}, 32'd1);
        check_value("rst_bus_outs", {28'd0, busRequest, beginTransaction, ramWriteEnable, lineDone}, 32'd0);
        check_value("rst_flags", {30'd0, overrun, busErrorFlag}, 32'd0);
        check_value("rst_addr", addressData | {24'd0, burstSize} | {23'd0, ramAddress} | ramDataIn, 32'd0);
        reset = 1'b0;
        step();

        // Line 1: 40 words from 0x1000, grant held off for a while
        frameBaseAddress = 32'h0000_1000;
        lineWords        = 8'd40;
        pulse_start();
        clear_log();
        busGrant = 1'b0;
        pulse_request();
        repeat (3) step();
        check_value("req_hold", {29'd0, busRequest, busy, beginTransaction}, 32'd6);
        busGrant = 1'b1;
        bus_line(0, 1'b0);
        check_bursts("l1", 3, 32'h0000_1000, 7);
        check_writes("l1", 40, 0);
        check_value("l1_done", done_cnt, 1);
        check_value("l1_readBank", {31'd0, readBank}, 32'd0);

        // Line 2: continues at 0x10A0 into bank 1, with a surplus beat ignored
        clear_log();
        pulse_request();
        bus_line(0, 1'b1);
        check_bursts("l2", 3, 32'h0000_10A0, 7);
        check_writes("l2", 40, 256);
        check_value("l2_readBank", {31'd0, readBank}, 32'd1);

        // Line 3: 256-word line
        clear_log();
        lineWords = 8'd0;
        pulse_request();
        bus_line(0, 1'b0);
        check_bursts("l3", 16, 32'h0000_1140, 15);
        check_writes("l3", 256, 0);
        check_value("l3_done", done_cnt, 1);

        // Line 4: address advanced by 0x400
        clear_log();
        lineWords = 8'd8;
        pulse_request();
        bus_line(0, 1'b0);
        check_bursts("l4", 1, 32'h0000_1540, 7);
        check_writes("l4", 8, 256);

        // Bus error on the fifth beat, then retry
        clear_log();
        pulse_request();
        bus_line(5, 1'b0);
        check_value("err_flag", {31'd0, busErrorFlag}, 32'd1);
        check_value("err_no_done", done_cnt, 0);
        check_value("err_idle", {31'd0, busy}, 32'd0);
        clear_log();
        pulse_request();
        bus_line(0, 1'b0);
        check_bursts("retry", 1, 32'h0000_1560, 7);
        check_writes("retry", 8, 0);
        check_value("retry_done", done_cnt, 1);
        check_value("retry_flag_sticky", {31'd0, busErrorFlag}, 32'd1);

        // lineRequest and startFrame while busy
        clear_log();
        frameBaseAddress = 32'h0000_2000;
        busGrant = 1'b0;
        pulse_request();
        lineRequest = 1'b1;
        startFrame  = 1'b1;
        step();
        lineRequest = 1'b0;
        startFrame  = 1'b0;
        check_value("ovr_flag", {31'd0, overrun}, 32'd1);
        busGrant = 1'b1;
        bus_line(0, 1'b0);
        check_bursts("ovr", 1, 32'h0000_1580, 7);
        check_writes("ovr", 8, 256);
        check_value("ovr_done", done_cnt, 1);
        clear_log();
        pulse_request();
        bus_line(0, 1'b0);
        check_bursts("rewind", 1, 32'h0000_2000, 7);
        check_writes("rewind", 8, 0);

        // startFrame and lineRequest in the same idle cycle
        clear_log();
        frameBaseAddress = 32'h0000_3000;
        startFrame  = 1'b1;
        lineRequest = 1'b1;
        step();
        startFrame  = 1'b0;
        lineRequest = 1'b0;
        check_value("both_flags_clr", {30'd0, overrun, busErrorFlag}, 32'd0);
        bus_line(0, 1'b0);
        check_bursts("both", 1, 32'h0000_3000, 7);
        check_writes("both", 8, 0);
        check_value("both_readBank", {31'd0, readBank}, 32'd0);

        // Reset in the middle of a burst
        clear_log();
        pulse_request();
        for (int g = 0; g < 20 && !beginTransaction; g++) step();
        check_value("mid_begin", {31'd0, beginTransaction}, 32'd1);
        step();
        dataValid = 1'b1;
        dataIn    = 32'hA500_0000;
        step();
        dataIn    = 32'hA500_0001;
        step();
        check_value("mid_pre_writes", wr_addr_q.size(), 2);
        dataValid = 1'b0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        dataValid = 1'b1;
        dataIn    = 32'h5555_AAAA;
        @(negedge clock);
        check_value("mid_rst_outs", {27'd0, busy, busRequest, ramWriteEnable, lineDone, beginTransaction}, 32'd0);
        check_value("mid_rst_readBank", {31'd0, readBank}, 32'd1);
        step();
        step();
        dataValid = 1'b0;
        step();
        check_value("mid_late_writes", wr_addr_q.size(), 2);
        check_value("mid_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
